// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : output_port_arbiter
//  Purpose  : Per-output-port switch allocator for a 5-port wormhole router.
//             Selects one input among those requesting this output, locks the
//             crossbar select for the whole packet (head..tail), and tracks
//             downstream buffer credits so a flit is only sent when the
//             downstream input buffer has a free slot.
//
//  Parameters
//    PORT_ID    : index (0..4) of the output port owned by this arbiter
//    BUF_DEPTH  : downstream buffer depth in flits / initial credits (1..15)
//
//  Ports
//    clk        in   1   clock, rising edge
//    rst        in   1   asynchronous reset, active low
//    req        in   5   per-input request (0 local,1 west,2 north,3 east,4 south)
//    rout_ports in  15   per-input route result, [3i+2:3i] for input i
//    flit_valid in   5   input i presents a flit
//    tail       in   5   flit presented by input i is a tail flit
//    credit_in  in   1   downstream freed one slot (one-cycle pulse)
//    grant      out  5   registered one-hot crossbar select (or zero)
//    send       out  1   combinational: a flit crosses this cycle
//    busy       out  1   a packet currently holds the port
//    credit_cnt out  4   current downstream credit count
//    cred_err   out  1   registered one-cycle pulse on credit overflow
//
//  Build option
//    ARB_ROUND_ROBIN_EN : when defined, round-robin arbitration with a
//                         rotating pointer; otherwise fixed priority
//                         local > west > north > east > south.
//
//  Revision : 1.0  initial release
// ============================================================================
module output_port_arbiter #(
  parameter int PORT_ID   = 0,
  parameter int BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req,
  input  logic [14:0] rout_ports,
  input  logic [4:0]  flit_valid,
  input  logic [4:0]  tail,
  input  logic        credit_in,
  output logic [4:0]  grant,
  output logic        send,
  output logic        busy,
  output logic [3:0]  credit_cnt,
  output logic        cred_err
);

  localparam int         c_NUM_IN    = 5;
  localparam logic [2:0] c_PORT_ID   = 3'(PORT_ID);
  localparam logic [3:0] c_BUF_DEPTH = 4'(BUF_DEPTH);

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_ACTIVE = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0] r_state;
  logic [4:0] r_grant;
  logic [3:0] r_credit;
  logic       r_cred_err;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [4:0] w_eligible;
  logic       w_any_eligible;
  logic       w_have_credit;
  logic       w_send;
  logic       w_tail_send;
  logic       w_cred_ovf;
  logic [2:0] w_win_idx;
  logic [4:0] w_win_onehot;

  // An input is a candidate only if it requests and its route targets us.
  generate
    for (genvar gi = 0; gi < c_NUM_IN; gi++) begin : g_elig
      assign w_eligible[gi] = req[gi] && (rout_ports[3*gi +: 3] == c_PORT_ID);
    end
  endgenerate

  assign w_any_eligible = |w_eligible;
  assign w_have_credit  = (r_credit != 4'd0);

  // Only the granted input's flit_valid matters; the credit check guarantees
  // the counter can never be decremented below zero.
  assign w_send      = (|(r_grant & flit_valid)) && w_have_credit;
  assign w_tail_send = w_send && (|(r_grant & tail));

  // A returned credit with a full counter and no concurrent send is bogus:
  // drop it and flag the error.
  assign w_cred_ovf  = credit_in && !w_send && (r_credit == c_BUF_DEPTH);

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] r_ptr;
  logic [3:0] w_cand;
  logic       w_found;

  // Search upward from the pointer, wrapping 4 -> 0; first eligible wins.
  always_comb begin
    w_win_idx = 3'd0;
    w_found   = 1'b0;
    w_cand    = 4'd0;
    for (int k = 0; k < c_NUM_IN; k++) begin
      w_cand = {1'b0, r_ptr} + 4'(k);
      if (w_cand >= 4'd5) begin
        w_cand = w_cand - 4'd5;
      end
      if (!w_found && w_eligible[w_cand[2:0]]) begin
        w_found   = 1'b1;
        w_win_idx = w_cand[2:0];
      end
    end
  end

  // The pointer only advances when a grant is actually issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 3'd0;
    end else if (r_state == c_IDLE && w_any_eligible && w_have_credit) begin
      r_ptr <= (w_win_idx == 3'd4) ? 3'd0 : (w_win_idx + 3'd1);
    end
  end
`else
  logic w_found;

  // Fixed priority: the lowest-numbered eligible input (local first) wins.
  always_comb begin
    w_win_idx = 3'd0;
    w_found   = 1'b0;
    for (int k = 0; k < c_NUM_IN; k++) begin
      if (!w_found && w_eligible[k]) begin
        w_found   = 1'b1;
        w_win_idx = 3'(k);
      end
    end
  end
`endif

  assign w_win_onehot = 5'b00001 << w_win_idx;

  // --------------------------------------------------------------------------
  // Allocation FSM
  //   IDLE   : arbitrate when a candidate exists and a credit is available.
  //   ACTIVE : grant is locked until the tail flit is sent; the release edge
  //            does not re-arbitrate, so packets are separated by one idle
  //            cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_grant <= 5'b00000;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_eligible && w_have_credit) begin
            r_grant <= w_win_onehot;
            r_state <= c_ACTIVE;
          end else begin
            r_grant <= 5'b00000;
          end
        end
        c_ACTIVE: begin
          if (w_tail_send) begin
            r_grant <= 5'b00000;
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_grant <= 5'b00000;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Credit counter: cnt - send + credit_in, overflow credits discarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit   <= c_BUF_DEPTH;
      r_cred_err <= 1'b0;
    end else begin
      r_cred_err <= w_cred_ovf;
      if (!w_cred_ovf) begin
        case ({w_send, credit_in})
          2'b10:   r_credit <= r_credit - 4'd1;
          2'b01:   r_credit <= r_credit + 4'd1;
          default: r_credit <= r_credit;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign grant      = r_grant;
  assign send       = w_send;
  assign busy       = (r_state == c_ACTIVE);
  assign credit_cnt = r_credit;
  assign cred_err   = r_cred_err;

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_port_arbiter
//  Purpose  : Directed scoreboard bench for output_port_arbiter (PORT_ID=2,
//             BUF_DEPTH=4). Each stimulus row pushes the hand-computed
//             expected outputs; a monitor pops and compares on the falling
//             edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_output_port_arbiter;

  localparam int         c_PORT_ID   = 2;
  localparam int         c_BUF_DEPTH = 4;
  localparam logic [14:0] c_RT_ALL   = {5{3'd2}};
  // east (input 3) routed to port 3, everyone else to port 2
  localparam logic [14:0] c_RT_EAST3 = {3'd2, 3'd3, 3'd2, 3'd2, 3'd2};

  logic        clk;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] rout_ports;
  logic [4:0]  flit_valid;
  logic [4:0]  tail;
  logic        credit_in;
  logic [4:0]  grant;
  logic        send;
  logic        busy;
  logic [3:0]  credit_cnt;
  logic        cred_err;

  output_port_arbiter #(
    .PORT_ID   (c_PORT_ID),
    .BUF_DEPTH (c_BUF_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rout_ports (rout_ports),
    .flit_valid (flit_valid),
    .tail       (tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .send       (send),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .cred_err   (cred_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         row;
    logic [4:0] g;
    logic       s;
    logic       b;
    logic [3:0] c;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   row_no = 0;

  task automatic chk(input string name, input int row, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, got, exp);
    end
  endtask

  // Monitor: compare whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("grant",      x.row, int'(grant),      int'(x.g));
      chk("send",       x.row, int'(send),       int'(x.s));
      chk("busy",       x.row, int'(busy),       int'(x.b));
      chk("credit_cnt", x.row, int'(credit_cnt), int'(x.c));
      chk("cred_err",   x.row, int'(cred_err),   int'(x.e));
    end
  end

  // One cycle: after the rising edge apply inputs, queue expected outputs.
  task automatic cyc(input logic rv, input logic [4:0] rq, input logic [14:0] rt,
                     input logic [4:0] fv, input logic [4:0] tl, input logic ci,
                     input logic [4:0] eg, input logic es, input logic eb,
                     input logic [3:0] ec, input logic ee);
    exp_t x;
    @(posedge clk);
    #1;
    rst        = rv;
    req        = rq;
    rout_ports = rt;
    flit_valid = fv;
    tail       = tl;
    credit_in  = ci;
    x.row = row_no;
    x.g = eg; x.s = es; x.b = eb; x.c = ec; x.e = ee;
    sb.push_back(x);
    row_no++;
  endtask

  logic [4:0] arb_order [6];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    // pointer is at 3 after the earlier local, west and north grants
    arb_order = '{5'b01000, 5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
`else
    arb_order = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = '0; rout_ports = '0; flit_valid = '0; tail = '0; credit_in = 1'b0;

    //   rst  req       route       fv        tail      ci    grant     s  b  cnt e
    // reset values, release reset
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    // local 3-flit packet, other requester waits
    cyc(1, 5'b00001, c_RT_ALL,   5'b00001, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    cyc(1, 5'b00001, c_RT_ALL,   5'b00001, 5'b00000, 0,    5'b00001, 1, 1, 4, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00001, 5'b00000, 0,    5'b00001, 1, 1, 3, 0);
    cyc(1, 5'b00010, c_RT_ALL,   5'b00001, 5'b00001, 0,    5'b00001, 1, 1, 2, 0);
    cyc(1, 5'b00010, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00000, 0, 0, 1, 0);
    // west single-flit packet
    cyc(1, 5'b00000, c_RT_ALL,   5'b00010, 5'b00010, 0,    5'b00010, 1, 1, 1, 0);
    // credits exhausted: north waits for a credit
    cyc(1, 5'b00100, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00000, 0, 0, 0, 0);
    cyc(1, 5'b00100, c_RT_ALL,   5'b00100, 5'b00000, 0,    5'b00000, 0, 0, 0, 0);
    cyc(1, 5'b00100, c_RT_ALL,   5'b00100, 5'b00000, 1,    5'b00000, 0, 0, 0, 0);
    cyc(1, 5'b00100, c_RT_ALL,   5'b00100, 5'b00000, 0,    5'b00000, 0, 0, 1, 0);
    cyc(1, 5'b00100, c_RT_ALL,   5'b00100, 5'b00000, 0,    5'b00100, 1, 1, 1, 0);
    // zero credit blocks send, then send+credit keeps count
    cyc(1, 5'b00000, c_RT_ALL,   5'b00100, 5'b00000, 1,    5'b00100, 0, 1, 0, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00100, 5'b00000, 1,    5'b00100, 1, 1, 1, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00100, 5'b00100, 0,    5'b00100, 1, 1, 1, 0);
    // refill credits, then overflow
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 1,    5'b00000, 0, 0, 0, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 1,    5'b00000, 0, 0, 1, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 1,    5'b00000, 0, 0, 2, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 1,    5'b00000, 0, 0, 3, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 1,    5'b00000, 0, 0, 4, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00000, 0, 0, 4, 1);
    // east routed elsewhere: no grant, foreign flit_valid ignored
    cyc(1, 5'b01000, c_RT_EAST3, 5'b11111, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    cyc(1, 5'b01000, c_RT_EAST3, 5'b11111, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    // everyone requests with single-flit packets
    cyc(1, 5'b11111, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    for (int p = 0; p < 6; p++) begin
      cyc(1, 5'b11111, c_RT_ALL, 5'b11111, 5'b11111, 1,    arb_order[p], 1, 1, 4, 0);
      cyc(1, (p < 5) ? 5'b11111 : 5'b00000, c_RT_ALL,
                                 5'b00000, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    end
    // west packet, aborted by reset with credit_cnt=2
    cyc(1, 5'b00010, c_RT_ALL,   5'b00010, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    cyc(1, 5'b00010, c_RT_ALL,   5'b00010, 5'b00000, 0,    5'b00010, 1, 1, 4, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00010, 5'b00000, 0,    5'b00010, 1, 1, 3, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00010, 0, 1, 2, 0);
    cyc(0, 5'b00000, c_RT_ALL,   5'b00010, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    // first arbitration on the first edge after release
    cyc(1, 5'b00001, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00000, 0, 0, 4, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00001, 0, 1, 4, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00001, 5'b00001, 0,    5'b00001, 1, 1, 4, 0);
    cyc(1, 5'b00000, c_RT_ALL,   5'b00000, 5'b00000, 0,    5'b00000, 0, 0, 3, 0);

    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 SHALL have parameter PORT_ID, default 0: index (0..4) of the output port this arbiter owns.
REQ-002 SHALL have parameter BUF_DEPTH, default 4: downstream input-buffer depth in flits and the initial credit count (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req  input  5  per-input request: bit0 local, bit1 west, bit2 north, bit3 east, bit4 south.
REQ-006 SHALL have port rout_ports  input  15  per-input route result; bits [3i+2:3i] belong to input i.
REQ-007 SHALL have port flit_valid  input  5  input i presents a flit this cycle.
REQ-008 SHALL have port tail  input  5  the flit presented by input i is a tail flit.
REQ-009 SHALL have port credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
REQ-010 SHALL have port grant  output  5  one-hot or zero; registered crossbar select for this output.
REQ-011 SHALL have port send  output  1  combinational; a flit crosses to the output this cycle.
REQ-012 SHALL have port busy  output  1  high while a packet holds the port (state ACTIVE).
REQ-013 SHALL have port credit_cnt  output  4  current downstream credit count.
REQ-014 SHALL have port cred_err  output  1  registered one-cycle pulse on credit overflow.

Function
REQ-015 SHALL define eligible[i] = req[i] AND (rout_ports[3i+2:3i] == PORT_ID).
REQ-016 SHALL implement a two-state FSM, IDLE and ACTIVE.
REQ-017 In IDLE, when any eligible[i] is set and credit_cnt != 0, the FSM SHALL load the winner's one-hot value into grant and enter ACTIVE at the next edge (one-cycle request-to-grant latency).
REQ-018 In IDLE with credit_cnt == 0, the FSM SHALL stay in IDLE with grant zero.
REQ-019 send SHALL equal OR over i of (grant[i] AND flit_valid[i]) AND (credit_cnt != 0); flit_valid from non-granted inputs SHALL be ignored.
REQ-020 In ACTIVE, grant SHALL be held unchanged (wormhole lock) regardless of req, until a send whose granted input has tail set.
REQ-021 On a tail send, the FSM SHALL clear grant and return to IDLE at the next edge; there SHALL be no re-arbitration in that cycle (exactly one idle cycle between packets).
REQ-022 A single-flit packet (head with tail set) SHALL release the port on its only send.
REQ-023 Each cycle, credit_cnt SHALL update as credit_cnt - send + credit_in; with send and credit_in both asserted it SHALL remain unchanged.
REQ-024 credit_in arriving while credit_cnt == BUF_DEPTH and send == 0 SHALL be ignored, and cred_err SHALL pulse high for one cycle.
REQ-025 credit_cnt SHALL never underflow; send is gated by REQ-019.

Reset
REQ-026 While rst is low: state IDLE, grant 0, busy 0, cred_err 0, credit_cnt = BUF_DEPTH, round-robin pointer 0.
REQ-027 A reset asserted mid-packet SHALL abort the packet immediately and asynchronously, without waiting for a tail flit.
REQ-028 The first arbitration SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-029 With macro ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first eligible input searching upward from pointer ptr (wrapping 4 to 0); on each grant, ptr SHALL become winner+1 mod 5.
REQ-030 Without ARB_ROUND_ROBIN_EN, the winner SHALL use fixed priority local > west > north > east > south, and no pointer register SHALL exist.

Verification
REQ-031 Reset, then req=00001 with local routed to PORT_ID -> grant=00001 one cycle later, busy=1, credit_cnt=4.
REQ-032 Granted local sends 3 flits (tail on the 3rd) with no credit_in -> credit_cnt goes 4,3,2,1; grant=0 the cycle after the tail; another requester is granted no earlier than the following cycle.
REQ-033 With ARB_ROUND_ROBIN_EN, req=11111 all routed to PORT_ID, single-flit packets -> grant order 00001, 00010, 00100, 01000, 10000, 00001; without the macro -> 00001 repeatedly.
REQ-034 credit_cnt=0 with an eligible request -> grant stays 0 until a credit_in pulse, then grant is issued one cycle later; send with credit_in in the same cycle -> credit_cnt unchanged; credit_in at credit_cnt=4 -> cred_err pulses once and credit_cnt stays 4.
REQ-035 rst driven low mid-packet with credit_cnt=2 -> grant=0, busy=0, credit_cnt=4 immediately; req deasserted mid-packet without tail -> grant held.
